// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lab_pkg
//  Description : Shared constants and state type for the fillscreen engine.
//                Frame geometry defaults, VGA coordinate/colour widths and
//                the scan state machine encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lab_pkg;

  // Default frame geometry (160x120 VGA adapter frame buffer)
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Adapter port widths
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage : lab_pkg
`default_nettype wire

// File: rtl/fillscreen_scan_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fillscreen_scan_ctr
//  Description : Nested column-major pixel counter. y is the inner counter
//                (0..SCREEN_H-1); x advances each time y wraps. Both counters
//                wrap only through explicit compares, never by overflow.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk   in   clock
//    rst   in   synchronous active-high reset, clears both counters
//    en    in   advance one pixel
//    clr   in   return to (0,0); has priority over en
//    last  out  high while the counter sits on (SCREEN_W-1, SCREEN_H-1)
//    x     out  current column
//    y     out  current row
// ============================================================================
module fillscreen_scan_ctr
  import lab_pkg::*;
#(
  parameter int SCREEN_W = lab_pkg::SCREEN_W,
  parameter int SCREEN_H = lab_pkg::SCREEN_H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clr,
  output logic           last,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  localparam logic [X_W-1:0] C_X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] C_Y_MAX = Y_W'(SCREEN_H - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_at_max;
  logic           w_y_at_max;

  assign w_x_at_max = (r_x == C_X_MAX);
  assign w_y_at_max = (r_y == C_Y_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (en) begin
      if (w_y_at_max) begin
        r_y <= '0;
        r_x <= w_x_at_max ? '0 : r_x + 1'b1;
      end else begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  assign last = w_x_at_max && w_y_at_max;
  assign x    = r_x;
  assign y    = r_y;

endmodule : fillscreen_scan_ctr
`default_nettype wire

// File: rtl/fillscreen.sv
`default_nettype none
// ============================================================================
//  Module      : fillscreen
//  Description : Paints every pixel of the frame exactly once per start
//                request, one pixel per clock in column-major order, then
//                signals completion through a level start/done handshake.
//                All outputs are registered, so each plotted pixel appears
//                one cycle after the scan counter holds it.
//  Revision    : 1.0 - initial release
//
//  Build option
//    FILLSCREEN_SOLID_EN  defined   : colour is captured when the fill starts
//                                     and used for every pixel of that fill
//                         undefined : vga_colour = x mod 8 (vertical stripes),
//                                     colour input is ignored
//
//  Ports
//    clk         in   clock
//    rst         in   synchronous active-high reset; abandons any fill
//    start       in   level fill request (rising level needed per fill)
//    colour      in   solid fill colour (solid build only)
//    done        out  fill complete, held until start drops
//    vga_x       out  pixel column
//    vga_y       out  pixel row
//    vga_colour  out  pixel colour
//    vga_plot    out  write strobe, one pixel per high cycle
// ============================================================================
module fillscreen
  import lab_pkg::*;
#(
  parameter int SCREEN_W = lab_pkg::SCREEN_W,
  parameter int SCREEN_H = lab_pkg::SCREEN_H
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COLOUR_W-1:0] colour,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  fill_state_e         r_state;
  fill_state_e         w_state_nxt;
  logic                w_ctr_en;
  logic                w_ctr_clr;
  logic                w_ctr_last;
  logic [X_W-1:0]      w_ctr_x;
  logic [Y_W-1:0]      w_ctr_y;
  logic [COLOUR_W-1:0] w_pix_colour;

  fillscreen_scan_ctr #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan_ctr (
    .clk  (clk),
    .rst  (rst),
    .en   (w_ctr_en),
    .clr  (w_ctr_clr),
    .last (w_ctr_last),
    .x    (w_ctr_x),
    .y    (w_ctr_y)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and counter control. The counter is held at (0,0) outside
  // FILL so every fill starts from the origin, including after a reset
  // that abandoned a partial fill.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_en    = 1'b0;
    w_ctr_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ctr_clr = 1'b1;
        if (start) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        // start is deliberately not looked at: a fill always completes
        w_ctr_en = 1'b1;
        if (w_ctr_last) begin
          w_ctr_clr   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_ctr_clr = 1'b1;
        if (!start) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_ctr_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pixel colour source
  // --------------------------------------------------------------------------
`ifdef FILLSCREEN_SOLID_EN
  logic [COLOUR_W-1:0] r_fill_colour;

  // Captured on the IDLE->FILL transition so mid-fill changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_colour <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_fill_colour <= colour;
    end
  end

  assign w_pix_colour = r_fill_colour;
`else
  logic w_colour_unused;

  assign w_colour_unused = ^colour;
  assign w_pix_colour    = w_ctr_x[COLOUR_W-1:0];
`endif

  // --------------------------------------------------------------------------
  // Registered outputs: one pipeline stage behind the scan counter, so the
  // pixel held by the counter in FILL is presented on the next cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      done     <= (r_state == DONE);
      vga_plot <= (r_state == FILL);
      if (r_state == FILL) begin
        vga_x      <= w_ctr_x;
        vga_y      <= w_ctr_y;
        vga_colour <= w_pix_colour;
      end else begin
        vga_x      <= '0;
        vga_y      <= '0;
        vga_colour <= '0;
      end
    end
  end

endmodule : fillscreen
`default_nettype wire

// File: doc/fillscreen.md
# fillscreen

Synthesizable pixel-scan engine that paints every pixel of the 160×120 VGA frame once per start request. It sits between the top-level KEY/clock glue and the VGA adapter: it consumes the start request and drives the adapter's x/y/colour/plot inputs, then reports completion through a start/done handshake. The top-level test sequence's ~19210-cycle run window is sized to this block's 19201-cycle fill latency.

## Interface
- `SCREEN_W`, default 160: horizontal pixel count; x range 0..SCREEN_W-1.
- `SCREEN_H`, default 120: vertical pixel count; y range 0..SCREEN_H-1.
- `clk` input, 1 bit: single clock, 50 MHz in the system.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: level request to fill the screen.
- `colour` input, 3 bits: fill colour; used only when `FILLSCREEN_SOLID_EN` is defined.
- `done` output, 1 bit: fill complete; held until `start` drops.
- `vga_x` output, 8 bits: pixel column.
- `vga_y` output, 7 bits: pixel row.
- `vga_colour` output, 3 bits: pixel colour.
- `vga_plot` output, 1 bit: write strobe; the adapter writes on every cycle it is high.

## Operation
- State machine with three states: IDLE, FILL, DONE.
- IDLE:
  - Outputs `vga_plot`=0, `done`=0, `vga_x`=0, `vga_y`=0.
  - `start`=1 sampled → FILL.
- FILL:
  - `vga_plot`=1 every cycle; exactly one pixel per cycle.
  - Scan is column-major: y is the inner counter 0..SCREEN_H-1; x increments when y wraps from SCREEN_H-1 to 0.
  - At (SCREEN_W-1, SCREEN_H-1) the pixel is plotted, then → DONE.
  - `start` falling during FILL is ignored; the fill always completes.
- DONE:
  - `done`=1, `vga_plot`=0; counters return to 0.
  - Stays in DONE while `start`=1.
  - `start`=0 → IDLE, with `done`=0 from the next cycle.
  - A new fill therefore requires a `start` low→high sequence.
- Colour:
  - `vga_colour` = `vga_x[2:0]` (x mod 8), or the registered `colour` per Configuration.
  - `vga_colour` is always valid when `vga_plot`=1.
- Arithmetic: x and y are unsigned; the counters never exceed SCREEN_W-1 / SCREEN_H-1 and wrap only via the explicit compare.
- `rst`=1 in any state → IDLE next edge, all outputs 0; a partial fill is abandoned, not resumed.
- `rst` and `start` high in the same cycle: `rst` wins.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `start` sampled high at edge N:
  - First plot (0,0) is visible after edge N+1.
  - Last plot (159,119) is visible after edge N+19200.
  - `done`=1 after edge N+19201.
- Total plots per fill: exactly SCREEN_W×SCREEN_H = 19200, with no gaps and no duplicates.
- `done` falls one cycle after `start` is sampled low in DONE.
- Reset values: `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.

## Configuration
- Macro `FILLSCREEN_SOLID_EN`.
- Defined:
  - `colour` is registered on the IDLE→FILL transition.
  - `vga_colour` equals that registered value for the whole fill; mid-fill changes to `colour` have no effect.
- Undefined:
  - `colour` is unused.
  - `vga_colour` = x mod 8 (vertical stripes 0..7 repeating).

## Structure
- `lab_pkg` holds:
  - `SCREEN_W`, `SCREEN_H` default constants.
  - Width constants `X_W`=8, `Y_W`=7, `COLOUR_W`=3.
  - State enum `fill_state_e` {IDLE, FILL, DONE}.
- One sub-module, `fillscreen_scan_ctr`:
  - Nested x/y counter with `en`, `clr`, `last` (high at the final pixel) and `x`/`y` outputs.
  - The FSM in `fillscreen` drives `en`/`clr` and uses `last` for FILL→DONE.

## Test plan
- Reset then `start`=1 held: first plot (0,0) one cycle after start; exactly 19200 plots, each (x,y) pair seen once; `done`=1 at cycle 19201; every pixel colour = x mod 8.
- Scoreboard order check: plot k has x=k/120 and y=k%120; plots 119→120 go (0,119)→(1,0).
- `start` dropped at cycle 500 of FILL: fill still completes 19200 plots; `done` pulses one cycle, then IDLE.
- `start` held high for 100 cycles after `done`: `done` stays 1 and there are no further plots. `start` low then high again: a second full fill of 19200 plots.
- `rst`=1 at plot 7000 for one cycle: `vga_plot`=0 and `done`=0 next cycle. Restart: the fill begins at (0,0) again.
- `FILLSCREEN_SOLID_EN` defined, `colour`=3'b101 at start, changed to 3'b010 mid-fill: all 19200 plots carry 3'b101.
